// File: rtl/xgmii_pkg.sv
`default_nettype none
// ============================================================================
// Package  : xgmii_pkg
// Brief    : Shared XGMII control codes, Ethernet framing constants, CRC-32
//            constants and the receive decoder state type.
// Revision : 1.0 - initial release
// ============================================================================
package xgmii_pkg;

  // XGMII control characters (valid when the lane control bit is 1)
  localparam logic [7:0] XGMII_IDLE   = 8'h07;
  localparam logic [7:0] XGMII_START  = 8'hFB;
  localparam logic [7:0] XGMII_TERM   = 8'hFD;
  localparam logic [7:0] XGMII_ERROR  = 8'hFE;

  // Ethernet preamble / start-of-frame delimiter
  localparam logic [7:0] ETH_PREAMBLE = 8'h55;
  localparam logic [7:0] ETH_SFD      = 8'hD5;
  localparam int         PREAMBLE_LEN = 6;

  // Reflected CRC-32; the running register over payload + FCS lands on RESIDUE
  localparam logic [31:0] CRC32_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC32_POLY    = 32'hEDB8_8320;
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB_20E3;

  // FCS is 4 bytes, so holding 5 bytes back lets the last payload byte carry tlast
  localparam int DELAY_DEPTH = 5;

  typedef enum logic [1:0] {
    RX_IDLE     = 2'd0,
    RX_PREAMBLE = 2'd1,
    RX_PAYLOAD  = 2'd2,
    RX_DROP     = 2'd3
  } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/eth_crc32_8.sv
`default_nettype none
// ============================================================================
// Module   : eth_crc32_8
// Brief    : Combinational byte-wide Ethernet CRC-32 update (reflected,
//            LSB-first). Shared between the RX decoder and TX encoder.
// Revision : 1.0 - initial release
// ============================================================================
module eth_crc32_8
  import xgmii_pkg::*;
(
  input  logic [31:0] i_crc_in,
  input  logic [7:0]  i_data,
  output logic [31:0] o_crc_out
);

  logic [31:0] w_crc;

  // Fold the byte in, then run eight LSB-first shift/XOR steps
  always_comb begin
    w_crc = i_crc_in ^ {24'h00_0000, i_data};
    for (int i = 0; i < 8; i++) begin
      if (w_crc[0]) begin
        w_crc = (w_crc >> 1) ^ CRC32_POLY;
      end else begin
        w_crc = w_crc >> 1;
      end
    end
    o_crc_out = w_crc;
  end

endmodule
`default_nettype wire

// File: rtl/xgmii_rx_decode.sv
`default_nettype none
// ============================================================================
// Module   : xgmii_rx_decode
// Brief    : Byte-wide XGMII receive decoder. Checks and strips preamble/SFD,
//            checks CRC-32 and length, strips FCS via a 5-byte delay line and
//            emits payload on a non-backpressurable AXI-stream master with
//            per-frame status pulses.
// Revision : 1.0 - initial release
// ============================================================================
module xgmii_rx_decode
  import xgmii_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CTRL_WIDTH = DATA_WIDTH / 8,
  parameter int MIN_FRAME  = 64,
  parameter int MAX_FRAME  = 1518
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] xgmii_d,
  input  logic [CTRL_WIDTH-1:0] xgmii_c,
  output logic [7:0]            m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  output logic                  stat_rx_frame_good,
  output logic                  stat_rx_frame_bad,
  output logic                  stat_rx_err_preamble
);

  generate
    if (DATA_WIDTH != 8) begin : g_bad_width
      $error("xgmii_rx_decode: only DATA_WIDTH = 8 is supported");
    end
  endgenerate

  localparam logic [15:0] C_MIN_LEN  = 16'(MIN_FRAME);
  localparam logic [15:0] C_MAX_LEN  = 16'(MAX_FRAME);
  localparam logic [15:0] C_LEN_SAT  = 16'hFFFF;
  localparam logic [2:0]  C_DL_FULL  = 3'(DELAY_DEPTH);
  localparam logic [2:0]  C_PRE_LAST = 3'(PREAMBLE_LEN);

  rx_state_t   r_state;
  logic [2:0]  r_pre_idx;
  logic [31:0] r_crc;
  logic [15:0] r_len;
  logic [7:0]  r_dl [DELAY_DEPTH];
  logic [2:0]  r_dl_cnt;

  logic [7:0]  r_tdata;
  logic        r_tvalid;
  logic        r_tlast;
  logic        r_tuser;
  logic        r_good;
  logic        r_bad;
  logic        r_err_pre;

  logic [7:0]  w_d;
  logic        w_c;
  logic [31:0] w_crc_next;
  logic        w_dl_full;
  logic        w_frame_bad;

  assign w_d         = xgmii_d[7:0];
  assign w_c         = xgmii_c[0];
  assign w_dl_full   = (r_dl_cnt == C_DL_FULL);
  // Saturated length 0xFFFF is naturally > MAX_FRAME
  assign w_frame_bad = (r_crc != CRC32_RESIDUE) || (r_len < C_MIN_LEN) || (r_len > C_MAX_LEN);

  eth_crc32_8 u_crc (
    .i_crc_in  (r_crc),
    .i_data    (w_d),
    .o_crc_out (w_crc_next)
  );

  // Receive FSM: framing, CRC/length tracking, FCS-stripping delay line, registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= RX_IDLE;
      r_pre_idx <= '0;
      r_crc     <= CRC32_INIT;
      r_len     <= '0;
      r_dl_cnt  <= '0;
      for (int i = 0; i < DELAY_DEPTH; i++) begin
        r_dl[i] <= '0;
      end
      r_tdata   <= '0;
      r_tvalid  <= 1'b0;
      r_tlast   <= 1'b0;
      r_tuser   <= 1'b0;
      r_good    <= 1'b0;
      r_bad     <= 1'b0;
      r_err_pre <= 1'b0;
    end else begin
      // Beat and status outputs are single-cycle pulses by default
      r_tvalid  <= 1'b0;
      r_tlast   <= 1'b0;
      r_tuser   <= 1'b0;
      r_good    <= 1'b0;
      r_bad     <= 1'b0;
      r_err_pre <= 1'b0;

      case (r_state)
        RX_IDLE: begin
          if (w_c && (w_d == XGMII_START)) begin
            r_state   <= RX_PREAMBLE;
            r_pre_idx <= '0;
          end
        end

        RX_PREAMBLE: begin
          if (!w_c && (r_pre_idx < C_PRE_LAST) && (w_d == ETH_PREAMBLE)) begin
            r_pre_idx <= r_pre_idx + 3'd1;
          end else if (!w_c && (r_pre_idx == C_PRE_LAST) && (w_d == ETH_SFD)) begin
            r_state  <= RX_PAYLOAD;
            r_crc    <= CRC32_INIT;
            r_len    <= '0;
            r_dl_cnt <= '0;
          end else begin
            r_state   <= RX_DROP;
            r_err_pre <= 1'b1;
            r_bad     <= 1'b1;
          end
        end

        RX_PAYLOAD: begin
          if (!w_c) begin
            r_crc   <= w_crc_next;
            r_dl[0] <= w_d;
            for (int i = DELAY_DEPTH - 1; i > 0; i--) begin
              r_dl[i] <= r_dl[i-1];
            end
            if (r_len != C_LEN_SAT) begin
              r_len <= r_len + 16'd1;
            end
            if (w_dl_full) begin
              r_tvalid <= 1'b1;
              r_tdata  <= r_dl[DELAY_DEPTH-1];
            end else begin
              r_dl_cnt <= r_dl_cnt + 3'd1;
            end
          end else if (w_d == XGMII_TERM) begin
            // Oldest held byte is the last payload byte; the rest is FCS
            if (w_dl_full) begin
              r_tvalid <= 1'b1;
              r_tdata  <= r_dl[DELAY_DEPTH-1];
              r_tlast  <= 1'b1;
              r_tuser  <= w_frame_bad;
              r_good   <= !w_frame_bad;
              r_bad    <= w_frame_bad;
            end else begin
              r_bad <= 1'b1;
            end
            r_state <= RX_IDLE;
          end else begin
            // Error/idle/start mid-frame: close out what was emitted as bad
            if (w_dl_full) begin
              r_tvalid <= 1'b1;
              r_tdata  <= r_dl[DELAY_DEPTH-1];
              r_tlast  <= 1'b1;
              r_tuser  <= 1'b1;
            end
            r_bad   <= 1'b1;
            r_state <= RX_IDLE;
          end
        end

        RX_DROP: begin
          if (w_c) begin
            r_state <= RX_IDLE;
          end
        end

        default: begin
          r_state <= RX_IDLE;
        end
      endcase
    end
  end

  assign m_axis_tdata         = r_tdata;
  assign m_axis_tvalid        = r_tvalid;
  assign m_axis_tlast         = r_tlast;
  assign m_axis_tuser         = r_tuser;
  assign stat_rx_frame_good   = r_good;
  assign stat_rx_frame_bad    = r_bad;
  assign stat_rx_err_preamble = r_err_pre;

endmodule
`default_nettype wire

// File: tb/tb_xgmii_rx_decode.sv
`default_nettype none
// ============================================================================
// Module   : tb_xgmii_rx_decode
// Brief    : Self-checking bench for xgmii_rx_decode: directed frame table,
//            hand-written corner sequences and randomized frames, checked
//            per cycle against an expectation schedule and per frame against
//            tabulated beat/status counts.
// Revision : 1.0 - initial release
// ============================================================================
module tb_xgmii_rx_decode;
  import xgmii_pkg::*;

  localparam int NSLOT = 40000;
  localparam int MIN_F = 64;
  localparam int MAX_F = 1518;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] xgmii_d = 8'h07;
  logic [0:0] xgmii_c = 1'b1;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid, m_axis_tlast, m_axis_tuser;
  logic       stat_rx_frame_good, stat_rx_frame_bad, stat_rx_err_preamble;

  xgmii_rx_decode #(
    .DATA_WIDTH(8), .CTRL_WIDTH(1), .MIN_FRAME(MIN_F), .MAX_FRAME(MAX_F)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .xgmii_d             (xgmii_d),
    .xgmii_c             (xgmii_c),
    .m_axis_tdata        (m_axis_tdata),
    .m_axis_tvalid       (m_axis_tvalid),
    .m_axis_tlast        (m_axis_tlast),
    .m_axis_tuser        (m_axis_tuser),
    .stat_rx_frame_good  (stat_rx_frame_good),
    .stat_rx_frame_bad   (stat_rx_frame_bad),
    .stat_rx_err_preamble(stat_rx_err_preamble)
  );

  always #5 clk = ~clk;

  // Expected output per cycle slot (default: everything idle)
  bit       e_v [NSLOT];
  bit [7:0] e_d [NSLOT];
  bit       e_l [NSLOT];
  bit       e_u [NSLOT];
  bit       e_g [NSLOT];
  bit       e_b [NSLOT];
  bit       e_p [NSLOT];

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int tot_beats = 0, tot_good = 0, tot_bad = 0, tot_pre = 0;
  logic [7:0] fr[$];

  typedef struct {
    int n; int mode; int endk; int pbad; bit pctrl;
    int beats; int good; int bad; int pre;
  } vec_t;
  vec_t tbl [16];

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, got, want);
    end
  endtask

  task automatic check_cycle();
    bit ok;
    int s;
    s  = cyc;
    ok = 1'b1;
    if (m_axis_tvalid !== e_v[s]) ok = 1'b0;
    if (e_v[s] && (m_axis_tdata !== e_d[s])) ok = 1'b0;
    if (m_axis_tlast !== e_l[s]) ok = 1'b0;
    if (e_l[s] && (m_axis_tuser !== e_u[s])) ok = 1'b0;
    if (stat_rx_frame_good !== e_g[s]) ok = 1'b0;
    if (stat_rx_frame_bad !== e_b[s]) ok = 1'b0;
    if (stat_rx_err_preamble !== e_p[s]) ok = 1'b0;
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL cycle %0d: got v=%b d=%h l=%b u=%b g=%b b=%b p=%b, want v=%b d=%h l=%b u=%b g=%b b=%b p=%b",
               s, m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser, stat_rx_frame_good,
               stat_rx_frame_bad, stat_rx_err_preamble, e_v[s], e_d[s], e_l[s], e_u[s],
               e_g[s], e_b[s], e_p[s]);
    end
    if (m_axis_tvalid === 1'b1)        tot_beats++;
    if (stat_rx_frame_good === 1'b1)   tot_good++;
    if (stat_rx_frame_bad === 1'b1)    tot_bad++;
    if (stat_rx_err_preamble === 1'b1) tot_pre++;
  endtask

  // One XGMII input cycle; outputs checked at the negedge of the same cycle
  task automatic drive(input bit c, input logic [7:0] d);
    xgmii_c = c;
    xgmii_d = d;
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic sched_beat(input int s, input logic [7:0] d, input bit last, input bit user);
    e_v[s] = 1'b1; e_d[s] = d; e_l[s] = last; e_u[s] = user;
  endtask

  function automatic logic [31:0] fcs_of_frame();
    logic [31:0] crc;
    crc = 32'hFFFF_FFFF;
    for (int i = 0; i < fr.size(); i++) begin
      for (int j = 0; j < 8; j++) begin
        if ((crc[0] ^ fr[i][j]) == 1'b1) crc = (crc >> 1) ^ 32'hEDB8_8320;
        else                             crc = crc >> 1;
      end
    end
    return ~crc;
  endfunction

  // mode 0: n raw bytes; mode 1: n-4 payload + correct FCS; mode 2: FCS last byte ^ 0x01
  task automatic build_frame(input int n, input int mode, input bit pat);
    logic [31:0] fcs;
    logic [7:0]  b;
    fr.delete();
    if (mode == 0) begin
      for (int i = 0; i < n; i++) begin
        b = pat ? i[7:0] : 8'($urandom);
        fr.push_back(b);
      end
    end else begin
      for (int i = 0; i < n - 4; i++) begin
        b = pat ? i[7:0] : 8'($urandom);
        fr.push_back(b);
      end
      fcs = fcs_of_frame();
      fr.push_back(fcs[7:0]);
      fr.push_back(fcs[15:8]);
      fr.push_back(fcs[23:16]);
      fr.push_back(fcs[31:24]);
      if (mode == 2) fr[n-1] = fr[n-1] ^ 8'h01;
    end
  endtask

  // Sends start, preamble/SFD and payload; schedules expected outputs.
  // endk: 0 terminate, 1 error, 2 idle, 3 start.  pbad: preamble index to corrupt (-1 none).
  task automatic send_frame(input int n, input int mode, input int endk,
                            input int pbad, input bit pctrl, input bit pat);
    logic [7:0] b;
    bit good;
    build_frame(n, mode, pat);
    drive(1'b1, XGMII_START);
    for (int i = 0; i < 7; i++) begin
      b = (i < 6) ? 8'h55 : 8'hD5;
      if (i == pbad) begin
        e_p[cyc+1] = 1'b1;
        e_b[cyc+1] = 1'b1;
        if (pctrl) drive(1'b1, XGMII_ERROR);
        else       drive(1'b0, b ^ 8'h01);
        repeat ($urandom_range(0, 2)) drive(1'b0, 8'($urandom));
        drive(1'b1, XGMII_IDLE);
        return;
      end
      drive(1'b0, b);
    end
    for (int k = 0; k < n; k++) begin
      if (k >= 5) sched_beat(cyc + 1, fr[k-5], 1'b0, 1'b0);
      drive(1'b0, fr[k]);
    end
    good = (mode == 1) && (n >= MIN_F) && (n <= MAX_F);
    if (endk == 0) begin
      if (n >= 5) begin
        sched_beat(cyc + 1, fr[n-5], 1'b1, !good);
        e_g[cyc+1] = good;
        e_b[cyc+1] = !good;
      end else begin
        e_b[cyc+1] = 1'b1;
      end
      drive(1'b1, XGMII_TERM);
    end else begin
      if (n >= 5) sched_beat(cyc + 1, fr[n-5], 1'b1, 1'b1);
      e_b[cyc+1] = 1'b1;
      case (endk)
        1:       drive(1'b1, XGMII_ERROR);
        2:       drive(1'b1, XGMII_IDLE);
        default: drive(1'b1, XGMII_START);
      endcase
    end
  endtask

  task automatic clear_from(input int s);
    for (int i = s; i < s + 16; i++) begin
      e_v[i] = 0; e_l[i] = 0; e_u[i] = 0; e_g[i] = 0; e_b[i] = 0; e_p[i] = 0;
    end
  endtask

  task automatic check_counts(input string name, input int b0, input int g0, input int x0,
                              input int p0, input int beats, input int good, input int bad,
                              input int pre);
    cmp($sformatf("%s beats", name), tot_beats - b0, beats);
    cmp($sformatf("%s good", name),  tot_good - g0,  good);
    cmp($sformatf("%s bad", name),   tot_bad - x0,   bad);
    cmp($sformatf("%s preerr", name), tot_pre - p0,  pre);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int b0, g0, x0, p0, r, n;
    //           n    mode endk pbad pctrl beats good bad pre
    tbl[0]  = '{64,   1, 0, -1, 0, 60,   1, 0, 0};
    tbl[1]  = '{64,   2, 0, -1, 0, 60,   0, 1, 0};
    tbl[2]  = '{64,   1, 0,  3, 0, 0,    0, 1, 1};
    tbl[3]  = '{64,   1, 0, -1, 0, 60,   1, 0, 0};
    tbl[4]  = '{20,   0, 1, -1, 0, 16,   0, 1, 0};
    tbl[5]  = '{3,    0, 0, -1, 0, 0,    0, 1, 0};
    tbl[6]  = '{32,   1, 0, -1, 0, 28,   0, 1, 0};
    tbl[7]  = '{63,   1, 0, -1, 0, 59,   0, 1, 0};
    tbl[8]  = '{1518, 1, 0, -1, 0, 1514, 1, 0, 0};
    tbl[9]  = '{1519, 1, 0, -1, 0, 1515, 0, 1, 0};
    tbl[10] = '{5,    1, 0, -1, 0, 1,    0, 1, 0};
    tbl[11] = '{4,    1, 0, -1, 0, 0,    0, 1, 0};
    tbl[12] = '{64,   1, 2, -1, 0, 60,   0, 1, 0};
    tbl[13] = '{64,   1, 0,  6, 1, 0,    0, 1, 1};
    tbl[14] = '{64,   1, 3, -1, 0, 60,   0, 1, 0};
    tbl[15] = '{64,   1, 0, -1, 0, 60,   1, 0, 0};

    // Reset state
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    cmp("reset outputs", 32'({m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
                              stat_rx_frame_good, stat_rx_frame_bad, stat_rx_err_preamble}), 32'd0);
    rst = 1'b1;
    repeat (4) drive(1'b1, XGMII_IDLE);

    // Directed frame table
    for (int t = 0; t < 16; t++) begin
      b0 = tot_beats; g0 = tot_good; x0 = tot_bad; p0 = tot_pre;
      send_frame(tbl[t].n, tbl[t].mode, tbl[t].endk, tbl[t].pbad, tbl[t].pctrl, 1'b1);
      repeat (2) drive(1'b1, XGMII_IDLE);
      check_counts($sformatf("row%0d", t), b0, g0, x0, p0,
                   tbl[t].beats, tbl[t].good, tbl[t].bad, tbl[t].pre);
    end

    // Back-to-back frames: start directly after terminate
    b0 = tot_beats; g0 = tot_good; x0 = tot_bad; p0 = tot_pre;
    send_frame(64, 1, 0, -1, 1'b0, 1'b1);
    send_frame(100, 1, 0, -1, 1'b0, 1'b0);
    repeat (2) drive(1'b1, XGMII_IDLE);
    check_counts("b2b", b0, g0, x0, p0, 156, 2, 0, 0);

    // Start character used as the DROP exit is not honoured
    b0 = tot_beats; g0 = tot_good; x0 = tot_bad; p0 = tot_pre;
    drive(1'b1, XGMII_START);
    drive(1'b0, 8'h55);
    drive(1'b0, 8'h55);
    e_p[cyc+1] = 1'b1; e_b[cyc+1] = 1'b1;
    drive(1'b0, 8'h12);
    drive(1'b1, XGMII_START);
    repeat (6) drive(1'b0, 8'h55);
    drive(1'b0, 8'hD5);
    for (int k = 0; k < 10; k++) drive(1'b0, 8'(k));
    drive(1'b1, XGMII_TERM);
    repeat (2) drive(1'b1, XGMII_IDLE);
    check_counts("dropexit", b0, g0, x0, p0, 0, 0, 1, 1);

    // Asynchronous reset at payload byte 30, then a clean frame
    build_frame(64, 1, 1'b1);
    drive(1'b1, XGMII_START);
    repeat (6) drive(1'b0, 8'h55);
    drive(1'b0, 8'hD5);
    for (int k = 0; k < 30; k++) begin
      if (k >= 5) sched_beat(cyc + 1, fr[k-5], 1'b0, 1'b0);
      drive(1'b0, fr[k]);
    end
    rst = 1'b0;
    #1;
    clear_from(cyc);
    cmp("async reset outputs", 32'({m_axis_tvalid, m_axis_tlast, m_axis_tuser, stat_rx_frame_good,
                                    stat_rx_frame_bad, stat_rx_err_preamble}), 32'd0);
    drive(1'b0, fr[30]);
    rst = 1'b1;
    repeat (2) drive(1'b1, XGMII_IDLE);
    b0 = tot_beats; g0 = tot_good; x0 = tot_bad; p0 = tot_pre;
    send_frame(64, 1, 0, -1, 1'b0, 1'b1);
    repeat (2) drive(1'b1, XGMII_IDLE);
    check_counts("postrst", b0, g0, x0, p0, 60, 1, 0, 0);

    // Randomized frames against the cycle schedule
    for (int f = 0; f < 40; f++) begin
      r = $urandom_range(0, 9);
      case (r)
        0: send_frame(64, 1, 0, $urandom_range(0, 6), 1'($urandom_range(0, 1)), 1'b0);
        1: begin n = $urandom_range(0, 80);  send_frame(n, 0, $urandom_range(1, 3), -1, 1'b0, 1'b0); end
        2: begin n = $urandom_range(4, 70);  send_frame(n, 1, 0, -1, 1'b0, 1'b0); end
        3: begin n = $urandom_range(0, 4);   send_frame(n, 0, 0, -1, 1'b0, 1'b0); end
        4: begin n = $urandom_range(64, 200); send_frame(n, 2, 0, -1, 1'b0, 1'b0); end
        default: begin n = $urandom_range(60, 200); send_frame(n, 1, 0, -1, 1'b0, 1'b0); end
      endcase
      repeat ($urandom_range(0, 3)) begin
        if ($urandom_range(0, 1) == 1) drive(1'b1, XGMII_IDLE);
        else                            drive(1'b0, 8'($urandom));
      end
    end
    repeat (3) drive(1'b1, XGMII_IDLE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
